// File: rtl/rob_multiport_if.sv
// Bundle between rename/dispatch, the CDB, the commit stage and the ROB.
// Master drives dispatch and CDB traffic; slave is the reorder buffer.
`timescale 1ns/1ps
interface rob_multiport_if #(
    parameter int DEPTH     = 16,
    parameter int DISP_W    = 2,
    parameter int CMT_W     = 2,
    parameter int CDB_W     = 2,
    parameter int TAG_WIDTH = 6
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DISP_W-1:0]                disp_valid;
    logic [DISP_W-1:0][4:0]           disp_rd;
    logic [DISP_W-1:0][TAG_WIDTH-1:0] disp_tag;
    logic [DISP_W-1:0]                disp_is_st;
    logic                             stall;
    logic                             disp_ready;
    logic [CNT_W-1:0]                 rob_count;

    logic [CDB_W-1:0]                 cdb_valid;
    logic [CDB_W-1:0][TAG_WIDTH-1:0]  cdb_tag;
    logic [CDB_W-1:0][31:0]           cdb_data;
    logic [CDB_W-1:0]                 cdb_exc;

    logic [CMT_W-1:0]                 cmt_valid;
    logic [CMT_W-1:0][4:0]            cmt_rd;
    logic [CMT_W-1:0][TAG_WIDTH-1:0]  cmt_tag;
    logic [CMT_W-1:0][31:0]           cmt_data;
    logic                             exc_flush;
    logic [TAG_WIDTH-1:0]             exc_tag;

    modport master (
        output disp_valid, disp_rd, disp_tag, disp_is_st, stall,
        output cdb_valid, cdb_tag, cdb_data, cdb_exc,
        input  disp_ready, rob_count,
        input  cmt_valid, cmt_rd, cmt_tag, cmt_data, exc_flush, exc_tag
    );

    modport slave (
        input  disp_valid, disp_rd, disp_tag, disp_is_st, stall,
        input  cdb_valid, cdb_tag, cdb_data, cdb_exc,
        output disp_ready, rob_count,
        output cmt_valid, cmt_rd, cmt_tag, cmt_data, exc_flush, exc_tag
    );
endinterface

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: one circular queue, DISP_W dispatch lanes,
// CDB_W writeback snoop ports, CMT_W in-order commit lanes, precise flush.
`timescale 1ns/1ps
module rob_multiport #(
    parameter int DEPTH     = 16,
    parameter int DISP_W    = 2,
    parameter int CMT_W     = 2,
    parameter int CDB_W     = 2,
    parameter int TAG_WIDTH = 6
) (
    input logic            clk,
    input logic            rst,
    rob_multiport_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TW    = TAG_WIDTH;

    typedef logic [PTR_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] ptr_t;

    logic [DEPTH-1:0]        r_valid;
    logic [DEPTH-1:0]        r_done;
    logic [DEPTH-1:0]        r_exc;
    logic [4:0]              r_rd   [DEPTH];
    logic [TW-1:0]           r_tag  [DEPTH];
    logic [31:0]             r_data [DEPTH];
    ptr_t                    r_head;
    ptr_t                    r_tail;
    logic                    r_flush_pending;
    logic [TW-1:0]           r_exc_tag;
    logic [CMT_W-1:0]        r_cmt_valid;
    logic [CMT_W-1:0][4:0]   r_cmt_rd;
    logic [CMT_W-1:0][TW-1:0] r_cmt_tag;
    logic [CMT_W-1:0][31:0]  r_cmt_data;

    logic [DEPTH-1:0]        w_valid_n;
    logic [DEPTH-1:0]        w_done_n;
    logic [DEPTH-1:0]        w_exc_n;
    logic [4:0]              w_rd_n   [DEPTH];
    logic [TW-1:0]           w_tag_n  [DEPTH];
    logic [31:0]             w_data_n [DEPTH];

    ptr_t                    w_count;
    idx_t                    w_hidx;
    logic                    w_exc_det;
    logic                    w_disp_ready;
    logic                    w_fire;
    logic                    w_contig;
    ptr_t                    w_nenq;
    idx_t                    w_eidx [DISP_W];
    logic [CMT_W-1:0]        w_cmt_mask;
    ptr_t                    w_ncmt;
    idx_t                    w_cidx [CMT_W];
    logic                    w_chain;
    logic                    w_hit;

    assign w_count = r_tail - r_head;
    assign w_hidx  = r_head[PTR_W-1:0];
    assign w_contig =
        (bus.disp_valid & (bus.disp_valid + DISP_W'(1))) == '0;

    // Head fault detection, dispatch admission and enqueue slot indices
    always_comb begin
        w_exc_det = !r_flush_pending && (w_count != '0) &&
                    r_valid[w_hidx] && r_done[w_hidx] && r_exc[w_hidx];
        w_disp_ready = (w_count <= ptr_t'(DEPTH - DISP_W)) &&
                       !r_flush_pending && !w_exc_det;
        w_fire = w_disp_ready && !bus.stall;
        w_nenq = '0;
        for (int i = 0; i < DISP_W; i++) begin
            w_eidx[i] = r_tail[PTR_W-1:0] + idx_t'(i);
            w_nenq    = w_nenq + ptr_t'(bus.disp_valid[i]);
        end
    end

    // In-order commit: lane k retires only if every older lane retires
    always_comb begin
        w_cmt_mask = '0;
        w_ncmt     = '0;
        w_chain    = !r_flush_pending;
        for (int k = 0; k < CMT_W; k++) begin
            w_cidx[k] = w_hidx + idx_t'(k);
            if (w_chain && (ptr_t'(k) < w_count) &&
                r_valid[w_cidx[k]] && r_done[w_cidx[k]] &&
                !r_exc[w_cidx[k]]) begin
                w_cmt_mask[k] = 1'b1;
                w_ncmt        = w_ncmt + ptr_t'(1);
            end else begin
                w_chain = 1'b0;
            end
        end
    end

    // Entry next state: CDB snoop, then commit, then enqueue, then flush
    always_comb begin
        w_valid_n = r_valid;
        w_done_n  = r_done;
        w_exc_n   = r_exc;
        w_rd_n    = r_rd;
        w_tag_n   = r_tag;
        w_data_n  = r_data;
        w_hit     = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            w_hit = 1'b0;
            for (int p = 0; p < CDB_W; p++) begin
                if (!w_hit && r_valid[e] && !r_done[e] &&
                    bus.cdb_valid[p] && (bus.cdb_tag[p] == r_tag[e])) begin
                    w_hit       = 1'b1;
                    w_done_n[e] = 1'b1;
                    w_exc_n[e]  = bus.cdb_exc[p];
                    w_data_n[e] = bus.cdb_data[p];
                end
            end
        end
        for (int k = 0; k < CMT_W; k++) begin
            if (w_cmt_mask[k]) begin
                w_valid_n[w_cidx[k]] = 1'b0;
            end
        end
        if (w_fire) begin
            for (int i = 0; i < DISP_W; i++) begin
                if (bus.disp_valid[i]) begin
                    w_valid_n[w_eidx[i]] = 1'b1;
                    w_done_n[w_eidx[i]]  = bus.disp_is_st[i];
                    w_exc_n[w_eidx[i]]   = 1'b0;
                    w_rd_n[w_eidx[i]]    = bus.disp_rd[i];
                    w_tag_n[w_eidx[i]]   = bus.disp_tag[i];
                    w_data_n[w_eidx[i]]  = '0;
                end
            end
        end
        if (r_flush_pending) begin
            w_valid_n = '0;
        end
    end

    // Control state, pointers and registered commit / flush outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid         <= '0;
            r_done          <= '0;
            r_exc           <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_flush_pending <= 1'b0;
            r_exc_tag       <= '0;
            r_cmt_valid     <= '0;
            r_cmt_rd        <= '0;
            r_cmt_tag       <= '0;
            r_cmt_data      <= '0;
        end else begin
            r_valid <= w_valid_n;
            r_done  <= w_done_n;
            r_exc   <= w_exc_n;
            if (r_flush_pending) begin
                r_head          <= '0;
                r_tail          <= '0;
                r_flush_pending <= 1'b0;
                r_cmt_valid     <= '0;
            end else begin
                r_head          <= r_head + w_ncmt;
                if (w_fire) begin
                    r_tail <= r_tail + w_nenq;
                end
                r_flush_pending <= w_exc_det;
                if (w_exc_det) begin
                    r_exc_tag <= r_tag[w_hidx];
                end
                r_cmt_valid <= w_cmt_mask;
                for (int k = 0; k < CMT_W; k++) begin
                    if (w_cmt_mask[k]) begin
                        r_cmt_rd[k]   <= r_rd[w_cidx[k]];
                        r_cmt_tag[k]  <= r_tag[w_cidx[k]];
                        r_cmt_data[k] <= r_data[w_cidx[k]];
                    end
                end
            end
        end
    end

    // Entry payload; only meaningful while the entry's valid bit is set
    always_ff @(posedge clk) begin
        r_rd   <= w_rd_n;
        r_tag  <= w_tag_n;
        r_data <= w_data_n;
    end

    // Dispatch lanes must be filled contiguously from lane 0
    a_disp_contig: assert property (
        @(posedge clk) disable iff (rst) w_fire |-> w_contig);

    assign bus.disp_ready = w_disp_ready;
    assign bus.rob_count  = w_count;
    assign bus.cmt_valid  = r_cmt_valid;
    assign bus.cmt_rd     = r_cmt_rd;
    assign bus.cmt_tag    = r_cmt_tag;
    assign bus.cmt_data   = r_cmt_data;
    assign bus.exc_flush  = r_flush_pending;
    assign bus.exc_tag    = r_exc_tag;
endmodule
